lru_assoc_cache: RTL

LRU_ASSOC_CACHE -- requirements
Module: lru_assoc_cache

---
 rtl/cache_pkg.sv | 31 +++
 rtl/lru_assoc_cache_if.sv | 42 ++++
 rtl/lru_tracker.sv | 71 +++++++
 rtl/lru_assoc_cache.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared types and helpers for the fully-associative LRU cache.
package cache_pkg;

  // Controller states. WRITEBACK and FILL are the only states that talk to memory.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOOKUP    = 3'd1,
    ST_WRITEBACK = 3'd2,
    ST_FILL      = 3'd3,
    ST_RESPOND   = 3'd4
  } cache_state_e;

  // Ages are carried at the widest supported size (16 ways -> 4 bits).
  localparam int AGE_MAX_W = 4;
  typedef logic [AGE_MAX_W-1:0] age_t;

  // Age of one line after an access: the touched line becomes youngest (0),
  // lines that were younger than the touched line grow one older, the rest keep.
  function automatic age_t age_update(age_t age, age_t touched_age, logic is_touched);
    age_t r;
    if (is_touched) begin
      r = '0;
    end else if (age < touched_age) begin
      r = age + age_t'(1);
    end else begin
      r = age;
    end
    return r;
  endfunction

endpackage

// File: rtl/lru_assoc_cache_if.sv
// CPU request/response channel and backing-memory channel of the cache.
//
// Handshakes:
//   req : a request transfers on a rising clock edge where req_valid && req_ready.
//         req_ready is high only while the cache is idle; other inputs are ignored.
//   resp: resp_valid is a single-cycle pulse; resp_hit and resp_rdata are
//         meaningful only in that cycle (resp_rdata only for reads).
//   mem : mem_valid and its address/data/write are held stable until the cycle
//         in which mem_ack is high; mem_ack is a one-cycle completion pulse.
interface lru_assoc_cache_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_hit;
  logic              mem_valid;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  // Cache side.
  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, mem_rdata, mem_ack,
    output req_ready, resp_valid, resp_rdata, resp_hit,
           mem_valid, mem_write, mem_addr, mem_wdata
  );

  // CPU + memory side.
  modport master (
    output req_valid, req_write, req_addr, req_wdata, mem_rdata, mem_ack,
    input  req_ready, resp_valid, resp_rdata, resp_hit,
           mem_valid, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/lru_tracker.sv
// Per-line age counters (a permutation of 0..WAYS-1) and victim selection.
module lru_tracker
  import cache_pkg::*;
#(
  parameter  int WAYS  = 4,
  localparam int IDX_W = $clog2(WAYS)
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      touch_en,
  input  logic [IDX_W-1:0]          touch_idx,
  input  logic [WAYS-1:0]           valid_vec,
  output logic [IDX_W-1:0]          victim_idx,
  output logic [WAYS*AGE_MAX_W-1:0] ages_flat
);

  logic [IDX_W-1:0] age_q [WAYS];
  logic [IDX_W-1:0] age_d [WAYS];
  age_t             touched_age;
  logic             found_invalid;

  // Next ages: apply the touch rule to every line when a line is accessed.
  always_comb begin
    touched_age = age_t'(age_q[touch_idx]);
    for (int i = 0; i < WAYS; i++) begin
      age_d[i] = age_q[i];
      if (touch_en) begin
        age_d[i] = IDX_W'(age_update(age_t'(age_q[i]), touched_age, touch_idx == IDX_W'(i)));
      end
    end
  end

  // Victim: lowest-index invalid line, otherwise the oldest line (age WAYS-1).
  always_comb begin
    victim_idx    = '0;
    found_invalid = 1'b0;
    for (int i = 0; i < WAYS; i++) begin
      if (!valid_vec[i] && !found_invalid) begin
        victim_idx    = IDX_W'(i);
        found_invalid = 1'b1;
      end
    end
    if (!found_invalid) begin
      for (int i = 0; i < WAYS; i++) begin
        if (age_q[i] == IDX_W'(WAYS - 1)) begin
          victim_idx = IDX_W'(i);
        end
      end
    end
  end

  // Debug view of the ages, zero-extended to the package age width.
  always_comb begin
    ages_flat = '0;
    for (int i = 0; i < WAYS; i++) begin
      ages_flat[i*AGE_MAX_W +: AGE_MAX_W] = age_t'(age_q[i]);
    end
  end

  // Age registers; reset gives line i age i so the set starts as a permutation.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < WAYS; i++) begin
        age_q[i] <= IDX_W'(i);
      end
    end else begin
      age_q <= age_d;
    end
  end

endmodule

// File: rtl/lru_assoc_cache.sv
// Fully-associative write-back cache, one word per line, LRU replacement.
module lru_assoc_cache
  import cache_pkg::*;
#(
  parameter  int ADDR_W = 8,
  parameter  int DATA_W = 8,
  parameter  int WAYS   = 4,
  localparam int IDX_W  = $clog2(WAYS)
) (
  input  logic                      clock,
  input  logic                      reset_n,
  lru_assoc_cache_if.slave          bus,
  output cache_state_e              dbg_state,
  output logic [WAYS*AGE_MAX_W-1:0] dbg_age
);

  cache_state_e      state_q, state_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [IDX_W-1:0]  victim_q, victim_d;

  logic [WAYS-1:0]   valid_q, valid_d;
  logic [WAYS-1:0]   dirty_q, dirty_d;
  logic [ADDR_W-1:0] tag_q  [WAYS];
  logic [ADDR_W-1:0] tag_d  [WAYS];
  logic [DATA_W-1:0] data_q [WAYS];
  logic [DATA_W-1:0] data_d [WAYS];

  logic              req_ready_q, req_ready_d;
  logic              resp_valid_q, resp_valid_d;
  logic              resp_hit_q, resp_hit_d;
  logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
  logic              mem_valid_q, mem_valid_d;
  logic              mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

  logic [WAYS-1:0]   hit_vec;
  logic              hit_any;
  logic [IDX_W-1:0]  hit_idx;
  logic [IDX_W-1:0]  lru_victim;
  logic              touch_en;
  logic [IDX_W-1:0]  touch_idx;

  lru_tracker #(.WAYS(WAYS)) u_lru (
    .clock      (clock),
    .reset_n    (reset_n),
    .touch_en   (touch_en),
    .touch_idx  (touch_idx),
    .valid_vec  (valid_q),
    .victim_idx (lru_victim),
    .ages_flat  (dbg_age)
  );

  // Parallel tag compare; the tag is the whole address so at most one line matches.
  always_comb begin
    hit_idx = '0;
    for (int i = 0; i < WAYS; i++) begin
      hit_vec[i] = valid_q[i] && (tag_q[i] == addr_q);
      if (hit_vec[i]) begin
        hit_idx = IDX_W'(i);
      end
    end
    hit_any = |hit_vec;
  end

  // Controller next state, line updates and registered outputs.
  always_comb begin
    state_d      = state_q;
    wr_d         = wr_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    victim_d     = victim_q;
    valid_d      = valid_q;
    dirty_d      = dirty_q;
    tag_d        = tag_q;
    data_d       = data_q;
    req_ready_d  = req_ready_q;
    resp_valid_d = 1'b0;
    resp_hit_d   = resp_hit_q;
    resp_rdata_d = resp_rdata_q;
    mem_valid_d  = mem_valid_q;
    mem_write_d  = mem_write_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    touch_en     = 1'b0;
    touch_idx    = hit_idx;

    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid && req_ready_q) begin
          wr_d        = bus.req_write;
          addr_d      = bus.req_addr;
          wdata_d     = bus.req_wdata;
          req_ready_d = 1'b0;
          state_d     = ST_LOOKUP;
        end
      end

      ST_LOOKUP: begin
        if (hit_any) begin
          touch_en     = 1'b1;
          touch_idx    = hit_idx;
          resp_hit_d   = 1'b1;
          resp_valid_d = 1'b1;
          state_d      = ST_RESPOND;
          if (wr_q) begin
            data_d[hit_idx]  = wdata_q;
            dirty_d[hit_idx] = 1'b1;
          end else begin
            resp_rdata_d = data_q[hit_idx];
          end
        end else begin
          victim_d = lru_victim;
          if (valid_q[lru_victim] && dirty_q[lru_victim]) begin
            mem_valid_d = 1'b1;
            mem_write_d = 1'b1;
            mem_addr_d  = tag_q[lru_victim];
            mem_wdata_d = data_q[lru_victim];
            state_d     = ST_WRITEBACK;
          end else if (!wr_q) begin
            mem_valid_d = 1'b1;
            mem_write_d = 1'b0;
            mem_addr_d  = addr_q;
            state_d     = ST_FILL;
          end else begin
            // Write miss into a free or clean line: a line is one word, so no fill.
            valid_d[lru_victim] = 1'b1;
            dirty_d[lru_victim] = 1'b1;
            tag_d[lru_victim]   = addr_q;
            data_d[lru_victim]  = wdata_q;
            touch_en            = 1'b1;
            touch_idx           = lru_victim;
            resp_hit_d          = 1'b0;
            resp_valid_d        = 1'b1;
            state_d             = ST_RESPOND;
          end
        end
      end

      ST_WRITEBACK: begin
        if (bus.mem_ack) begin
          dirty_d[victim_q] = 1'b0;
          if (wr_q) begin
            valid_d[victim_q] = 1'b1;
            dirty_d[victim_q] = 1'b1;
            tag_d[victim_q]   = addr_q;
            data_d[victim_q]  = wdata_q;
            touch_en          = 1'b1;
            touch_idx         = victim_q;
            mem_valid_d       = 1'b0;
            mem_write_d       = 1'b0;
            resp_hit_d        = 1'b0;
            resp_valid_d      = 1'b1;
            state_d           = ST_RESPOND;
          end else begin
            mem_write_d = 1'b0;
            mem_addr_d  = addr_q;
            state_d     = ST_FILL;
          end
        end
      end

      ST_FILL: begin
        if (bus.mem_ack) begin
          valid_d[victim_q] = 1'b1;
          dirty_d[victim_q] = 1'b0;
          tag_d[victim_q]   = addr_q;
          data_d[victim_q]  = bus.mem_rdata;
          touch_en          = 1'b1;
          touch_idx         = victim_q;
          mem_valid_d       = 1'b0;
          resp_rdata_d      = bus.mem_rdata;
          resp_hit_d        = 1'b0;
          resp_valid_d      = 1'b1;
          state_d           = ST_RESPOND;
        end
      end

      ST_RESPOND: begin
        req_ready_d = 1'b1;
        state_d     = ST_IDLE;
      end

      default: begin
        req_ready_d = 1'b1;
        mem_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  // State, line storage and output registers; reset drops everything in flight.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      wr_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      victim_q     <= '0;
      valid_q      <= '0;
      dirty_q      <= '0;
      for (int i = 0; i < WAYS; i++) begin
        tag_q[i]  <= '0;
        data_q[i] <= '0;
      end
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_hit_q   <= 1'b0;
      resp_rdata_q <= '0;
      mem_valid_q  <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      wr_q         <= wr_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      victim_q     <= victim_d;
      valid_q      <= valid_d;
      dirty_q      <= dirty_d;
      tag_q        <= tag_d;
      data_q       <= data_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_hit_q   <= resp_hit_d;
      resp_rdata_q <= resp_rdata_d;
      mem_valid_q  <= mem_valid_d;
      mem_write_q  <= mem_write_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_hit   = resp_hit_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.mem_valid  = mem_valid_q;
  assign bus.mem_write  = mem_write_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign dbg_state      = state_q;

endmodule
